matbi_elastic_buffer: RTL and testbench

Parametrised elastic buffer: the multi-entry successor to the two-entry skid buffer, used for timing closure and rate decoupling on valid/ready streams between the AXI peripheral IPs and compute cores. It provides DEPTH entries, first-word-fall-through output, a fully registered `s_ready`, occupancy/almost-full status and a synchronous flush. Full throughput of one beat per cycle is sustained while not full.

---
 rtl/matbi_elastic_buffer_pkg.sv | 26 ++
 rtl/matbi_elastic_buf_mem.sv | 34 +++
 rtl/matbi_elastic_buffer.sv | 128 ++++++++++++
 tb/tb_matbi_elastic_buffer.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/matbi_elastic_buffer_pkg.sv
// rtl/matbi_elastic_buffer_pkg.sv - width helpers shared by the stream IPs
// Purpose: constant functions deriving pointer and occupancy-counter widths
// from an entry count, so every stream block sizes its counters the same way.
package matbi_elastic_buffer_pkg;

  // Ceiling log2; clog2(1) is 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

  // Pointer width for a DEPTH-entry buffer, never narrower than one bit.
  function automatic int ptr_width(input int depth);
    return (clog2(depth) < 1) ? 1 : clog2(depth);
  endfunction

  // Counter width able to hold the values 0..depth inclusive.
  function automatic int count_width(input int depth);
    return clog2(depth + 1);
  endfunction

endpackage

// File: rtl/matbi_elastic_buf_mem.sv
// rtl/matbi_elastic_buf_mem.sv - storage array behind the output register
// Purpose: ENTRIES x DATA_WIDTH register array, one write port, one
// asynchronous read port. Storage is deliberately not reset.
// Ports:
//   clk   - clock
//   we    - write enable
//   waddr - write address
//   wdata - write payload
//   raddr - read address
//   rdata - read payload (combinational from raddr)
module matbi_elastic_buf_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int ENTRIES    = 3,
  parameter int AW         = 2
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [ENTRIES];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/matbi_elastic_buffer.sv
// rtl/matbi_elastic_buffer.sv - DEPTH-entry first-word-fall-through elastic buffer
// Purpose: decouples a valid/ready producer from its consumer. The head beat
// lives in a registered output stage; the remaining DEPTH-1 beats sit in a
// circular array. s_ready and almost_full are registered from the next-state
// occupancy, so neither has a combinational path from m_ready.
// Ports:
//   clk, rst    - clock, asynchronous active-high reset
//   flush       - synchronous clear of all entries (outranks push/pop)
//   s_valid/s_ready/s_data - upstream stream
//   m_valid/m_ready/m_data - downstream stream (registered outputs)
//   count       - beats held, output register included
//   almost_full - count >= AFULL_LVL (registered)
module matbi_elastic_buffer
  import matbi_elastic_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,
  parameter int AFULL_LVL  = DEPTH - 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [DATA_WIDTH-1:0]         s_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [DATA_WIDTH-1:0]         m_data,
  output logic [count_width(DEPTH)-1:0] count,
  output logic                          almost_full
);

  localparam int PW      = ptr_width(DEPTH);
  localparam int CW      = count_width(DEPTH);
  localparam int ENTRIES = DEPTH - 1;

  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_LVL);
  localparam logic [CW-1:0] ONE_C    = CW'(1);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 2);

  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [DATA_WIDTH-1:0] mem_rdata;

  logic          push;
  logic          pop;
  logic          arr_empty;
  logic          load_direct;
  logic          refill;
  logic          mem_we;
  logic [CW-1:0] count_next;

  // The array holds DEPTH-1 entries, so pointers wrap after index DEPTH-2
  // rather than at the natural power-of-two boundary.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    push        = s_valid && s_ready;
    pop         = m_valid && m_ready;
    // Output register is always occupied when count is non-zero, so the
    // array holds count-1 beats.
    arr_empty   = (count <= ONE_C);
    // Beat bypasses the array when the output stage is, or is becoming, empty.
    load_direct = push && (!m_valid || (pop && arr_empty));
    refill      = pop && !arr_empty;
    mem_we      = push && !load_direct && !flush;
    count_next  = count + CW'(push) - CW'(pop);
  end

  matbi_elastic_buf_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ENTRIES    (ENTRIES),
    .AW         (PW)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_ptr),
    .wdata (s_data),
    .raddr (rd_ptr),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_ready     <= 1'b0;
      m_valid     <= 1'b0;
      m_data      <= '0;
      count       <= '0;
      almost_full <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else if (flush) begin
      s_ready     <= 1'b1;
      m_valid     <= 1'b0;
      count       <= '0;
      almost_full <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      count       <= count_next;
      s_ready     <= (count_next < DEPTH_C);
      almost_full <= (count_next >= AFULL_C);

      if (mem_we) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end

      // refill and load_direct are mutually exclusive: a direct load with a
      // valid output stage requires the array to be empty.
      if (refill) begin
        m_data <= mem_rdata;
        rd_ptr <= ptr_inc(rd_ptr);
      end else if (load_direct) begin
        m_data <= s_data;
      end

      if (refill || load_direct) begin
        m_valid <= 1'b1;
      end else if (pop) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_matbi_elastic_buffer.sv
// tb/tb_matbi_elastic_buffer.sv - scoreboard bench for matbi_elastic_buffer
module tb_matbi_elastic_buffer;

  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_data = '0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic [2:0]    count;
  logic          almost_full;

  int checks   = 0;
  int failures = 0;
  int pops     = 0;

  logic [DW-1:0] exp_q[$];

  matbi_elastic_buffer #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .AFULL_LVL  (DEPTH - 1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .count       (count),
    .almost_full (almost_full)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issuer: inputs are stable from posedge+1 to the next posedge, so what is
  // seen at the negedge is what the next edge will act on.
  always @(negedge clk) begin
    if (rst || flush) begin
      exp_q.delete();
    end else if (s_valid && s_ready) begin
      exp_q.push_back(s_data);
    end
  end

  // Monitor: every beat leaving the buffer must match the oldest issued beat.
  always @(negedge clk) begin
    if (!rst && !flush && m_valid && m_ready) begin
      pops = pops + 1;
      checks = checks + 1;
      if (exp_q.size() == 0) begin
        failures = failures + 1;
        $display("FAIL sb_unexpected: got 0x%0h expected no beat at %0t", m_data, $time);
      end else begin
        logic [DW-1:0] e;
        e = exp_q.pop_front();
        if (m_data !== e) begin
          failures = failures + 1;
          $display("FAIL sb_data: got 0x%0h expected 0x%0h at %0t", m_data, e, $time);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    #12;
    check("rst_s_ready", 32'(s_ready), 32'd0);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_afull", 32'(almost_full), 32'd0);
    check("rst_m_data", 32'(m_data), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #2;
    check("rel_s_ready_before_edge", 32'(s_ready), 32'd0);
    step();
    check("rel_s_ready_after_edge", 32'(s_ready), 32'd1);
    check("rel_m_valid", 32'(m_valid), 32'd0);

    // Continuous stream 0x01..0x10
    m_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      s_valid = 1'b1;
      s_data  = 8'(i);
      step();
      check("stream_m_valid", 32'(m_valid), 32'd1);
      check("stream_m_data", 32'(m_data), 32'(i));
      check("stream_count", 32'(count), 32'd1);
      check("stream_s_ready", 32'(s_ready), 32'd1);
    end
    s_valid = 1'b0;
    step();
    check("stream_drain_count", 32'(count), 32'd0);
    check("stream_drain_m_valid", 32'(m_valid), 32'd0);

    // Fill to full with m_ready low
    m_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      s_valid = 1'b1;
      s_data  = 8'hA0 + 8'(k - 1);
      step();
      check("fill_count", 32'(count), 32'(k));
      check("fill_afull", 32'(almost_full), (k >= 3) ? 32'd1 : 32'd0);
      check("fill_s_ready", 32'(s_ready), (k < 4) ? 32'd1 : 32'd0);
      check("fill_m_data_hold", 32'(m_data), 32'hA0);
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    step();
    check("drain1_count", 32'(count), 32'd3);
    check("drain1_s_ready", 32'(s_ready), 32'd1);
    check("drain1_afull", 32'(almost_full), 32'd1);
    step();
    check("drain2_count", 32'(count), 32'd2);
    check("drain2_afull", 32'(almost_full), 32'd0);
    step();
    step();
    check("drain_empty_count", 32'(count), 32'd0);
    check("drain_empty_m_valid", 32'(m_valid), 32'd0);

    // Simultaneous push/pop at count 2 across pointer wrap
    m_ready = 1'b0;
    s_valid = 1'b1;
    s_data  = 8'hB0;
    step();
    s_data  = 8'hB1;
    step();
    check("pp_pre_count", 32'(count), 32'd2);
    m_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      s_data = 8'hB2 + 8'(k);
      step();
      check("pp_count", 32'(count), 32'd2);
      check("pp_m_data", 32'(m_data), 32'(8'hB1 + 8'(k)));
    end
    s_valid = 1'b0;
    step();
    step();
    check("pp_drain_count", 32'(count), 32'd0);

    // Flush with count 3 and a beat offered
    m_ready = 1'b0;
    s_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      s_data = 8'hC0 + 8'(k);
      step();
    end
    check("fl_pre_count", 32'(count), 32'd3);
    flush   = 1'b1;
    s_data  = 8'hC3;
    m_ready = 1'b1;
    step();
    flush   = 1'b0;
    s_valid = 1'b0;
    check("fl_count", 32'(count), 32'd0);
    check("fl_m_valid", 32'(m_valid), 32'd0);
    check("fl_s_ready", 32'(s_ready), 32'd1);
    check("fl_afull", 32'(almost_full), 32'd0);
    step();
    step();
    check("fl_post_m_valid", 32'(m_valid), 32'd0);

    // Asynchronous reset between edges, then a fresh stream
    m_ready = 1'b0;
    s_valid = 1'b1;
    s_data  = 8'hD0;
    step();
    s_data  = 8'hD1;
    step();
    s_valid = 1'b0;
    check("ar_pre_count", 32'(count), 32'd2);
    #2;
    rst = 1'b1;
    #1;
    check("ar_m_valid", 32'(m_valid), 32'd0);
    check("ar_count", 32'(count), 32'd0);
    check("ar_s_ready", 32'(s_ready), 32'd0);
    check("ar_m_data", 32'(m_data), 32'd0);
    check("ar_afull", 32'(almost_full), 32'd0);
    step();
    rst = 1'b0;
    step();
    check("ar_rel_s_ready", 32'(s_ready), 32'd1);
    pops    = 0;
    m_ready = 1'b1;
    s_valid = 1'b1;
    s_data  = 8'h55;
    step();
    check("ar_first_m_data", 32'(m_data), 32'h55);
    s_data  = 8'h56;
    step();
    check("ar_second_m_data", 32'(m_data), 32'h56);
    s_valid = 1'b0;
    step();
    step();
    check("ar_pops", 32'(pops), 32'd2);
    check("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
